// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation and FSM state encodings plus the default operand width.
package ex_muldiv_ctrl_pkg;

    localparam int unsigned DEF_REG_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
interface ex_muldiv_ctrl_if
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH
);
    logic                 start;
    logic [1:0]           op;
    logic [REG_WIDTH-1:0] dataA;
    logic [REG_WIDTH-1:0] dataB;
    logic                 flush;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic [REG_WIDTH-1:0] result;

    modport master (
        output start, op, dataA, dataB, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op, dataA, dataB, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_ctrl_datapath.sv
// Accumulator and per-iteration step for shift-add multiply and restoring divide.
// Multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient}.
module ex_muldiv_ctrl_datapath #(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_div,
    input  logic                 i_dbz,
    input  logic                 i_step,
    input  logic [REG_WIDTH-1:0] i_a,
    input  logic [REG_WIDTH-1:0] i_b,
    output logic [REG_WIDTH-1:0] o_hi,
    output logic [REG_WIDTH-1:0] o_lo
);
    localparam int unsigned W = REG_WIDTH;

    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_b;
    logic           r_div;

    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;
    logic [W:0]     w_sum;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_mul_next;
    logic [2*W-1:0] w_div_next;

    assign w_hi = r_acc[2*W-1:W];
    assign w_lo = r_acc[W-1:0];

    // Carry-out of the add lands in w_sum[W] and shifts down into the top bit.
    assign w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_mul_next = {w_sum, w_lo[W-1:1]};

    // Shifted remainder is below 2*divisor, so bit W of the difference is the borrow.
    assign w_rem_sh   = {w_hi, w_lo[W-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[W] ? {w_rem_sh[W-1:0], w_lo[W-2:0], 1'b0}
                                  : {w_diff[W-1:0],   w_lo[W-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_div <= i_div;
            r_b   <= i_div ? i_b : i_a;
            if (i_dbz)
                r_acc <= {i_a, {W{1'b1}}};
            else
                r_acc <= {{W{1'b0}}, (i_div ? i_a : i_b)};
        end else if (i_step) begin
            r_acc <= r_div ? w_div_next : w_mul_next;
        end
    end

    assign o_hi = w_hi;
    assign o_lo = w_lo;
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer for the EX stage; stalls the
// pipeline while iterating and presents the result for exactly one cycle.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_ctrl_if.slave  bus
);
    localparam int unsigned CNT_WIDTH = $clog2(REG_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(REG_WIDTH - 1);

    md_state_e              r_state;
    md_state_e              w_state_next;
    md_op_e                 r_op;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_accept;
    logic                   w_dbz;
    logic                   w_done;
    logic [REG_WIDTH-1:0]   w_hi;
    logic [REG_WIDTH-1:0]   w_lo;
    logic [REG_WIDTH-1:0]   w_field;

    assign w_accept = (r_state == MD_IDLE) & bus.start & ~bus.flush;
    assign w_dbz    = md_is_div(bus.op) & (bus.dataB == '0);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= MD_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= MD_MUL;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= md_op_e'(bus.op);
            r_cnt <= '0;
        end else if (r_state == MD_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            MD_IDLE: if (w_accept) w_state_next = w_dbz ? MD_DONE : MD_BUSY;
            MD_BUSY: if (r_cnt == LAST_ITER) w_state_next = MD_DONE;
            MD_DONE: w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
        if (bus.flush)
            w_state_next = MD_IDLE;
    end

    ex_muldiv_ctrl_datapath #(
        .REG_WIDTH (REG_WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_div  (md_is_div(bus.op)),
        .i_dbz  (w_dbz),
        .i_step (r_state == MD_BUSY),
        .i_a    (bus.dataA),
        .i_b    (bus.dataB),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    always_comb begin
        w_field = '0;
        unique case (r_op)
            MD_MUL:   w_field = w_lo;
            MD_MULHU: w_field = w_hi;
            MD_DIVU:  w_field = w_lo;
            MD_REMU:  w_field = w_hi;
            default:  w_field = '0;
        endcase
    end

    assign w_done     = (r_state == MD_DONE) & ~bus.flush;
    assign bus.done   = w_done;
    assign bus.busy   = (r_state != MD_IDLE);
    assign bus.stall  = w_accept | (r_state == MD_BUSY);
    assign bus.result = w_done ? w_field : '0;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed corner cases plus random
// operations compared against plain-arithmetic results and latencies.
module tb_ex_muldiv_ctrl;
    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ex_muldiv_ctrl_if #(.REG_WIDTH(W)) bus ();

    ex_muldiv_ctrl #(.REG_WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned ref_latency(input logic [1:0] op, input logic [31:0] b);
        return (op[1] && b == 0) ? 1 : W + 1;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int unsigned k = 0;
        int unsigned stall_cnt = 0;
        bit          seen = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.dataA = a;
        bus.dataB = b;
        bus.flush = 1'b0;
        #1;
        if (bus.stall) stall_cnt++;
        while (!seen && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) begin
                bus.op    = 2'($urandom);
                bus.dataA = $urandom;
                bus.dataB = $urandom;
            end
            if (bus.done) begin
                seen = 1;
                res  = bus.result;
                check({tag, ".stall_at_done"}, 64'(bus.stall), 64'd0);
                check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd1);
            end else if (bus.stall) begin
                stall_cnt++;
            end
        end
        check({tag, ".latency"}, 64'(k), 64'(ref_latency(op, b)));
        check({tag, ".result"}, 64'(res), 64'(ref_result(op, a, b)));
        check({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(ref_latency(op, b)));
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, ".done_after"}, 64'(bus.done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"}, 64'(bus.stall), 64'd0);
        check({tag, ".busy"}, 64'(bus.busy), 64'd0);
        check({tag, ".done"}, 64'(bus.done), 64'd0);
        check({tag, ".result"}, 64'(bus.result), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned done_cnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.dataA = '0;
        bus.dataB = '0;
        bus.flush = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        run_op(2'd0, 32'd7, 32'd6, "mul_7x6");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
        run_op(2'd2, 32'd100, 32'd7, "divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, "remu_100_7");
        run_op(2'd2, 32'd5, 32'd0, "divu_by0");
        run_op(2'd3, 32'd5, 32'd0, "remu_by0");
        run_op(2'd2, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

        // Flush in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.dataA = 32'd100; bus.dataB = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        #1;
        check("flush_busy.done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        check("flush_busy.busy_next", 64'(bus.busy), 64'd0);
        check("flush_busy.stall_next", 64'(bus.stall), 64'd0);
        bus.flush = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("flush_busy.no_done", 64'(done_cnt), 64'd0);
        run_op(2'd0, 32'd3, 32'd4, "mul_after_flush");

        // Flush landing on the completion cycle of a divide-by-zero.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.dataA = 32'd5; bus.dataB = 32'd0;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        #1;
        check("flush_done.done", 64'(bus.done), 64'd0);
        check("flush_done.result", 64'(bus.result), 64'd0);
        @(posedge clk);
        #1;
        check("flush_done.busy_next", 64'(bus.busy), 64'd0);
        bus.flush = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.dataA = 32'd9; bus.dataB = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid");
        reset = 1'b0;
        run_op(2'd1, 32'h8000_0000, 32'd4, "mulhu_after_reset");

        // start together with flush in IDLE is not accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd0; bus.dataA = 32'd3; bus.dataB = 32'd4;
        #1;
        check("start_flush.stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        check("start_flush.busy", 64'(bus.busy), 64'd0);
        check("start_flush.stall_next", 64'(bus.stall), 64'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;

        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle unsigned multiply/divide sequencer attached to the EX stage, alongside the single-cycle ALU.
- Accepts an operation from the ID/EX register, already post-forwarding.
- Holds the pipeline with a stall while an iterative shift-add multiply or restoring divide runs.
- Presents the result for exactly one cycle, then releases the stall.
- The stage_EX result mux selects this block's result whenever done=1.

Parameters:
REG_WIDTH, 32, operand/result width (from `REG_WIDTH).
CNT_WIDTH, $clog2(REG_WIDTH)+1, iteration counter width (derived localparam, not overridable).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  ID/EX instruction is a mul/div op; held high until done
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
dataA  input  REG_WIDTH  forwarded rs1 value (multiplicand/dividend)
dataB  input  REG_WIDTH  forwarded rs2 value (multiplier/divisor)
flush  input  1  branch/exception flush of the EX stage
stall  output  1  hold PC, IF/ID and ID/EX; bubble EX/MEM
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse; result valid
result  output  REG_WIDTH  product/quotient/remainder; valid only when done=1

Behaviour:
- Reset:
  - state=IDLE; counter, accumulators and result cleared to 0.
  - stall=0, busy=0, done=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and flush=0 and divisor≠0 (or op is MUL/MULHU): latch op, dataA, dataB; clear the 2*REG_WIDTH accumulator; counter=0; go to BUSY.
  - DIVU/REMU with dataB=0: go straight to DONE. result = all-ones (DIVU) or dataA (REMU), per RISC-V.
- BUSY: one iteration per cycle, counter++. After iteration REG_WIDTH-1 completes (counter reaches REG_WIDTH), go to DONE.
  - MUL: if multiplier LSB is 1, add multiplicand to the upper half; shift the accumulator right 1. Carry-out is kept in an extra bit.
  - DIV: shift the {remainder, quotient} pair left 1; trial-subtract the divisor from the remainder. If non-negative, commit and set quotient LSB to 1.
- DONE:
  - done=1, stall=0; result driven from the latched op's field (low product, high product, quotient, remainder).
  - Next state IDLE unconditionally. start is ignored in DONE, since it still reflects the completing instruction.
- Latency: a start accepted at cycle T gives done=1 at cycle T+REG_WIDTH+1 (T+33 at default). Divide-by-zero gives done at T+1.
- stall = (IDLE & start & ~flush) | BUSY. Combinational, so the pipeline freezes in the acceptance cycle itself.
- Inputs dataA/dataB/op are sampled only at acceptance. Changes during BUSY have no effect.
- flush: in any state, next state is IDLE. done is suppressed that cycle and no result is delivered. flush has priority over start.
- reset mid-operation: same as flush; all registers return to reset values next cycle.
- start deasserted while BUSY (should not occur): no effect; the operation completes.
- busy = (state≠IDLE); done implies busy.

Decomposition:
- Shared package/header risc_v_defines.vh holds:
  - MULDIV op encodings (MD_MUL, MD_MULHU, MD_DIVU, MD_REMU);
  - FSM state encodings (MD_IDLE, MD_BUSY, MD_DONE);
  - REG_WIDTH.
- One natural sub-module: muldiv_datapath, holding the accumulator, shift/add/subtract and iteration step. ex_muldiv_ctrl keeps the FSM, counter, stall/done logic and result select.

Test Plan:
1. MUL: dataA=7, dataB=6, start held -> stall=1 for 33 cycles, then done=1 for one cycle with result=42; next cycle busy=0.
2. MULHU: dataA=0xFFFF_FFFF, dataB=0xFFFF_FFFF -> result=0xFFFF_FFFE (MUL on the same operands gives 0x0000_0001).
3. DIVU/REMU: dataA=100, dataB=7 -> DIVU gives result=14; REMU gives result=2; latency 33 cycles each.
4. Divide by zero: DIVU dataA=5, dataB=0 -> done at T+1 with result=0xFFFF_FFFF; REMU gives result=5; stall high for one cycle only.
5. flush at BUSY cycle 10 of DIVU 100/7 -> next cycle state=IDLE, stall=0, no done pulse. A new MUL 3*4 started afterward returns 12.
6. reset asserted mid-MUL, and start+flush asserted together in IDLE -> reset returns all outputs to 0 next cycle; start+flush is not accepted (stall=0, busy stays 0).
